reset_sequencer: RTL and testbench

//  Power-on/lock-loss reset controller feeding the DCM clock generator and the DDR/system logic.

---
 rtl/reset_sequencer_pkg.sv | 49 ++++
 rtl/reset_sequencer_if.sv | 24 ++
 rtl/reset_sequencer_sync_2ff.sv | 20 ++
 rtl/reset_sequencer.sv | 123 ++++++++++++
 tb/tb_reset_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer shared types: FSM state encoding, default timing
// and the state-to-reset-output decode.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    DCM_RST   = 3'd0,
    LOCK_WAIT = 3'd1,
    SETTLE    = 3'd2,
    CALIB     = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam int DEF_CNT_W          = 24;
  localparam int DEF_DCM_RST_CYCLES = 8;
  localparam int DEF_LOCK_TIMEOUT   = 33000;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_CALIB_TIMEOUT  = 3300000;
  localparam int DEF_MAX_RETRY      = 7;

  typedef struct packed {
    logic dcm_rst;
    logic ddr_rst;
    logic sys_rst;
    logic fault;
  } rst_out_t;

  function automatic rst_out_t decode(state_t s);
    rst_out_t o;
    o = '{dcm_rst: 1'b0, ddr_rst: 1'b1,
          sys_rst: 1'b1, fault: 1'b0};
    unique case (1'b1)
      (s == DCM_RST): o.dcm_rst = 1'b1;
      (s == CALIB):   o.ddr_rst = 1'b0;
      (s == RUN): begin
        o.ddr_rst = 1'b0;
        o.sys_rst = 1'b0;
      end
      (s == FAULT): begin
        o.dcm_rst = 1'b1;
        o.fault   = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer board-side bundle: DCM/DDR status in,
// reset outputs and debug status out.
interface reset_sequencer_if;
  logic       locked;
  logic       calib_done;
  logic       dcm_rst;
  logic       ddr_rst;
  logic       sys_rst;
  logic       fault;
  logic [2:0] state;
  logic [3:0] retry_count;

  modport master (
    input  locked, calib_done,
    output dcm_rst, ddr_rst, sys_rst,
    output fault, state, retry_count
  );

  modport slave (
    output locked, calib_done,
    input  dcm_rst, ddr_rst, sys_rst,
    input  fault, state, retry_count
  );
endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous level input,
// cleared by the synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: DCM/DDR/system reset FSM on the raw board clock.
// RSTSEQ_CALIB_WAIT_EN adds the wait for DDR calib_done before sys_rst.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int DCM_RST_CYCLES = DEF_DCM_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int CALIB_TIMEOUT  = DEF_CALIB_TIMEOUT,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input logic         clk,
  input logic         rst,
  reset_sequencer_if.master bus
);

  localparam longint LIM = longint'(1) << CNT_W;

  if (DCM_RST_CYCLES < 3 ||
      longint'(DCM_RST_CYCLES) >= LIM ||
      longint'(LOCK_TIMEOUT) >= LIM ||
      longint'(STABLE_CYCLES) >= LIM ||
      longint'(CALIB_TIMEOUT) >= LIM) begin : g_bad_timing
    $error("reset_sequencer: timing parameter out of range");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_retry
    $error("reset_sequencer: MAX_RETRY must be 1..15");
  end

  localparam logic [CNT_W-1:0] C_DCM    = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LOCK   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CALIB  = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_MAX    = '1;
  localparam logic [3:0]       R_MAX    = 4'(MAX_RETRY);

  logic             locked_s;
  logic             calib_s;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       retry, retry_n, retry_inc;
  rst_out_t         outs;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.locked),
    .q   (locked_s)
  );

`ifdef RSTSEQ_CALIB_WAIT_EN
  sync_2ff u_calib_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.calib_done),
    .q   (calib_s)
  );
`else
  logic unused_calib;
  assign unused_calib = bus.calib_done;
  assign calib_s      = 1'b0;
`endif

  assign retry_inc = (retry == R_MAX) ? retry : retry + 4'd1;

  always_comb begin
    state_n = state;
    retry_n = retry;
    case (state)
      DCM_RST:
        if (cnt == C_DCM) state_n = LOCK_WAIT;
      LOCK_WAIT:
        if (locked_s)           state_n = SETTLE;
        else if (cnt == C_LOCK) state_n = FAIL;
      SETTLE:
        if (!locked_s) state_n = FAIL;
        else if (cnt == C_STABLE) begin
`ifdef RSTSEQ_CALIB_WAIT_EN
          state_n = CALIB;
`else
          state_n = RUN;
`endif
        end
      // lock loss outranks calib_done and the timeout
      CALIB:
        if (!locked_s)           state_n = FAIL;
        else if (calib_s)        state_n = RUN;
        else if (cnt == C_CALIB) state_n = FAIL;
      RUN:
        if (!locked_s) state_n = FAIL;
      FAIL: begin
        retry_n = retry_inc;
        state_n = (retry_inc >= R_MAX) ? FAULT : DCM_RST;
      end
      default: state_n = FAULT;
    endcase
    if (state_n == RUN && state != RUN) retry_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DCM_RST;
      cnt   <= '0;
      retry <= '0;
      outs  <= decode(DCM_RST);
    end else begin
      state <= state_n;
      retry <= retry_n;
      outs  <= decode(state_n);
      if (state_n != state) cnt <= '0;
      else if (cnt != C_MAX) cnt <= cnt + 1'b1;
    end
  end

  assign bus.dcm_rst     = outs.dcm_rst;
  assign bus.ddr_rst     = outs.ddr_rst;
  assign bus.sys_rst     = outs.sys_rst;
  assign bus.fault       = outs.fault;
  assign bus.state       = state;
  assign bus.retry_count = retry;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scenario bench for reset_sequencer with short
// timing parameters; expectations queued then matched against outputs.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int P_ST  = 0;
  localparam int P_DCM = 1;
  localparam int P_DDR = 2;
  localparam int P_SYS = 3;
  localparam int P_FLT = 4;
  localparam int P_RTY = 5;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reset_sequencer_if bus();

  reset_sequencer #(
    .CNT_W          (24),
    .DCM_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .CALIB_TIMEOUT  (30),
    .MAX_RETRY      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;
  int   n;

  task automatic check(input string tag, input int obs,
                       input int exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic observe(input int obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  function automatic int probe(input int sel);
    case (sel)
      P_ST:    return int'(bus.state);
      P_DCM:   return int'(bus.dcm_rst);
      P_DDR:   return int'(bus.ddr_rst);
      P_SYS:   return int'(bus.sys_rst);
      P_FLT:   return int'(bus.fault);
      default: return int'(bus.retry_count);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int sel, input int val,
                           output int cnt);
    cnt = 0;
    while (probe(sel) != val && cnt < LIMIT) begin
      tick();
      cnt++;
    end
  endtask

  task automatic expect_outs(input string t, input int st,
                             input int dcm, input int ddr,
                             input int sys, input int flt,
                             input int rty);
    expect_v({t, ".state"}, st);
    expect_v({t, ".dcm_rst"}, dcm);
    expect_v({t, ".ddr_rst"}, ddr);
    expect_v({t, ".sys_rst"}, sys);
    expect_v({t, ".fault"}, flt);
    expect_v({t, ".retry"}, rty);
    observe(probe(P_ST));
    observe(probe(P_DCM));
    observe(probe(P_DDR));
    observe(probe(P_SYS));
    observe(probe(P_FLT));
    observe(probe(P_RTY));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    bus.locked     = 1'b0;
    bus.calib_done = 1'b0;
    rst            = 1'b1;
    tick(); tick(); tick();
    expect_outs("reset", DCM_RST, 1, 1, 1, 0, 0);

    // nominal bring-up
    rst = 1'b0;
    expect_v("dcm_pulse", 4);
    run_until(P_DCM, 0, n); observe(n);
    expect_v("lock_wait", LOCK_WAIT);
    observe(probe(P_ST));
    repeat (10) tick();
    expect_v("lock_to_settle", 3);
    bus.locked = 1'b1;
    run_until(P_ST, SETTLE, n); observe(n);
    expect_v("settle_to_ddr", 8);
    run_until(P_DDR, 0, n); observe(n);
`ifdef RSTSEQ_CALIB_WAIT_EN
    expect_v("calib_sys_held", 1);
    observe(probe(P_SYS));
    expect_v("calib_to_sys", 3);
    bus.calib_done = 1'b1;
    run_until(P_SYS, 0, n); observe(n);
`else
    expect_v("sys_with_ddr", 0);
    observe(probe(P_SYS));
`endif
    expect_outs("run", RUN, 0, 0, 0, 0, 0);

`ifdef RSTSEQ_CALIB_WAIT_EN
    bus.calib_done = 1'b0;
    repeat (5) tick();
    expect_outs("calib_drop", RUN, 0, 0, 0, 0, 0);
    bus.calib_done = 1'b1;
`endif

    // lock loss in RUN
    expect_v("loss_to_sys", 3);
    bus.locked = 1'b0;
    run_until(P_SYS, 1, n); observe(n);
    expect_outs("loss_fail", FAIL, 0, 1, 1, 0, 0);
    tick();
    expect_outs("loss_retry", DCM_RST, 1, 1, 1, 0, 1);
    expect_v("redo_dcm", 4);
    bus.locked = 1'b1;
    run_until(P_DCM, 0, n); observe(n);
    run_until(P_ST, RUN, n);
    expect_outs("rerun", RUN, 0, 0, 0, 0, 0);

    // glitch in SETTLE
    bus.locked = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    run_until(P_DCM, 0, n);
    bus.locked = 1'b1;
    run_until(P_ST, SETTLE, n);
    tick(); tick();
    bus.locked = 1'b0;
    expect_v("glitch_fail", 3);
    run_until(P_ST, FAIL, n); observe(n);
    tick();
    expect_outs("glitch_retry", DCM_RST, 1, 1, 1, 0, 1);
    expect_v("glitch_dcm", 4);
    run_until(P_DCM, 0, n); observe(n);

    // lock timeout until fault
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_v("to_dcm", 4);
      run_until(P_DCM, 0, n); observe(n);
      expect_v("to_wait", 20);
      run_until(P_ST, FAIL, n); observe(n);
      tick();
      if (i < 2)
        expect_outs("to_retry", DCM_RST, 1, 1, 1, 0, i + 1);
    end
    expect_outs("fault", FAULT, 1, 1, 1, 1, 3);
    bus.locked = 1'b1;
    repeat (40) tick();
    expect_outs("fault_sticky", FAULT, 1, 1, 1, 1, 3);

    // rst in FAULT, LOCK_WAIT and mid dcm pulse
    rst = 1'b1;
    tick();
    expect_outs("rst_fault", DCM_RST, 1, 1, 1, 0, 0);
    bus.locked = 1'b0;
    rst = 1'b0;
    run_until(P_DCM, 0, n);
    repeat (5) tick();
    expect_v("mid_lock_wait", LOCK_WAIT);
    observe(probe(P_ST));
    rst = 1'b1;
    tick();
    expect_outs("rst_lock_wait", DCM_RST, 1, 1, 1, 0, 0);
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_v("restart_dcm", 4);
    run_until(P_DCM, 0, n); observe(n);

`ifdef RSTSEQ_CALIB_WAIT_EN
    bus.calib_done = 1'b0;
    bus.locked     = 1'b1;
    run_until(P_ST, CALIB, n);
    expect_v("calib_timeout", 30);
    run_until(P_ST, FAIL, n); observe(n);
`endif

    if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
